// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type, ID width and counter-width helper for serial_add_arbiter
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int ID_W = 1;
  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++)
      if ((1 << r) >= v) return r;
    return 32;
  endfunction
endpackage

// File: rtl/fa_bit.sv
// fa_bit: 1-bit combinational full adder shared by the serial datapath
module fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin shares one full-adder cell between two requesters, LSB-first bit-serial add.
// Optional SERIAL_ADD_SUB_EN adds per-requester subtract (A-B, cout=1 means no borrow).
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [ID_W-1:0]  resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout
`ifdef SERIAL_ADD_SUB_EN
  ,
  input  logic             req0_sub,
  input  logic             req1_sub
`endif
);
  localparam int CW = clog2(WIDTH);
  state_e            state_q;
  logic              last_grant_q;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q;
  logic [CW-1:0]     cnt_q;
  logic              idle, grant0, grant1, fa_sum, fa_cout, cin_d;
  logic [WIDTH-1:0]  a_d, b_d;
`ifdef SERIAL_ADD_SUB_EN
  logic              sub_d;
`endif
  // last_grant resets to 1 so requester 0 wins the first tie
  always_comb begin
    idle   = state_q == IDLE;
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & ~grant0;
    a_d    = grant1 ? req1_a : req0_a;
`ifdef SERIAL_ADD_SUB_EN
    sub_d  = grant1 ? req1_sub : req0_sub;
    b_d    = (grant1 ? req1_b : req0_b) ^ {WIDTH{sub_d}};
    cin_d  = sub_d | (grant1 ? req1_cin : req0_cin);
`else
    b_d    = grant1 ? req1_b : req0_b;
    cin_d  = grant1 ? req1_cin : req0_cin;
`endif
  end
  assign req0_ready = idle & grant0;
  assign req1_ready = idle & grant1;
  assign resp_valid = state_q == DONE;
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = carry_q;
  fa_bit u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant0 | grant1) begin
          a_q          <= a_d;
          b_q          <= b_d;
          carry_q      <= cin_d;
          sum_q        <= '0;
          id_q         <= ID_W'(grant1);
          last_grant_q <= grant1;
          cnt_q        <= '0;
          state_q      <= SHIFT;
        end
        SHIFT: begin
          sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed vectors with a response scoreboard for serial_add_arbiter.
// Build with SERIAL_ADD_SUB_EN defined to also exercise subtraction.
module tb_serial_add_arbiter;
  localparam int W = 8;
  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic [31:0]  cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req0_cin = 0, req1_valid = 0, req1_cin = 0, resp_ready = 1;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, resp_valid, resp_cout;
  logic [0:0] resp_id;
  logic [W-1:0] resp_sum;
`ifdef SERIAL_ADD_SUB_EN
  logic req0_sub = 0, req1_sub = 0;
`endif
  logic [W:0] exp0 = 0, exp1 = 0;
  exp_t sb[$];
  int errors = 0, checks = 0;
  logic [31:0] cyc = 0;
  logic prev_v = 0;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_sum(resp_sum), .resp_cout(resp_cout)
`ifdef SERIAL_ADD_SUB_EN
    , .req0_sub(req0_sub), .req1_sub(req1_sub)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // accept monitor: a handshake seen here completes on the next rising edge
  always @(negedge clk) if (rst_n) begin
    if (req0_valid && req0_ready) sb.push_back('{1'b0, exp0[W-1:0], exp0[W], cyc + 1});
    if (req1_valid && req1_ready) sb.push_back('{1'b1, exp1[W-1:0], exp1[W], cyc + 1});
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid && !prev_v && sb.size() > 0) chk("latency", cyc - sb[0].cyc, W);
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id=%0d sum=0x%0h, no response required", resp_id, resp_sum);
      end else begin
        e = sb.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_sum", 32'(resp_sum), 32'(e.sum));
        chk("resp_cout", 32'(resp_cout), 32'(e.cout));
      end
    end
    prev_v = resp_valid;
  end

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] s, input logic co);
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_cin = cin; exp0 = {co, s};
`ifdef SERIAL_ADD_SUB_EN
      req0_sub = sub;
`endif
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; exp1 = {co, s};
`ifdef SERIAL_ADD_SUB_EN
      req1_sub = sub;
`endif
    end
  endtask

  task automatic wait_acc(output int who);
    who = -1;
    for (int i = 0; i < 200 && who < 0; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) who = 0;
      else if (req1_valid && req1_ready) who = 1;
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, required one within 200 cycles");
    end
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic [W-1:0] s, input logic co);
    int who;
    set_op(id, a, b, cin, sub, s, co);
    if (id == 0) req0_valid = 1; else req1_valid = 1;
    wait_acc(who);
    chk("grant_id", who, id);
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int who, n0, n1;
    #12;
    chk("rst_valid", resp_valid, 0);
    chk("rst_sum", resp_sum, 0);
    chk("rst_cout", resp_cout, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(posedge clk); #2 rst_n = 1;
    issue(0, 8'h3C, 8'h0F, 0, 0, 8'h4B, 0);
    drain();
    issue(1, 8'hFF, 8'h01, 0, 0, 8'h00, 1);
    drain();
    issue(1, 8'hFF, 8'hFF, 1, 0, 8'hFF, 1);
    drain();
    // both requesters valid: grants must alternate starting with 0
    set_op(0, 8'h01, 8'h02, 0, 0, 8'h03, 0);
    set_op(1, 8'h05, 8'h06, 0, 0, 8'h0B, 0);
    req0_valid = 1; req1_valid = 1; n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_acc(who);
      chk("rr_order", who, k % 2);
      if (who == 0) begin
        n0++;
        if (n0 == 1) set_op(0, 8'h10, 8'h20, 0, 0, 8'h30, 0); else req0_valid = 0;
      end else begin
        n1++;
        if (n1 == 1) set_op(1, 8'h40, 8'h41, 0, 0, 8'h81, 0); else req1_valid = 0;
      end
    end
    req0_valid = 0; req1_valid = 0;
    drain();
    chk("rr_count0", n0, 2);
    chk("rr_count1", n1, 2);
    // backpressure: result held, no accepts while stalled
    resp_ready = 0;
    issue(0, 8'h81, 8'h90, 0, 0, 8'h11, 1);
    set_op(1, 8'h22, 8'h33, 1, 0, 8'h56, 0);
    req1_valid = 1;
    for (int i = 0; i < 50 && !resp_valid; i++) @(negedge clk);
    chk("bp_valid_seen", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_sum", resp_sum, 8'h11);
      chk("bp_cout", resp_cout, 1);
      chk("bp_id", resp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
    end
    @(posedge clk); #2 resp_ready = 1;
    @(negedge clk);
    chk("hs_ready1", req1_ready, 0);
    @(negedge clk);
    chk("post_hs_valid", resp_valid, 0);
    chk("post_hs_ready1", req1_ready, 1);
    @(posedge clk); #2 req1_valid = 0;
    drain();
    // asynchronous reset in the middle of SHIFT
    issue(1, 8'hAA, 8'h11, 0, 0, 8'hBB, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_sum", resp_sum, 0);
    chk("mid_rst_cout", resp_cout, 0);
    chk("mid_rst_id", resp_id, 0);
    chk("mid_rst_ready0", req0_ready, 0);
    chk("mid_rst_ready1", req1_ready, 0);
    sb.delete();
    @(posedge clk); #2 rst_n = 1;
    issue(0, 8'h12, 8'h34, 0, 0, 8'h46, 0);
    drain();
`ifdef SERIAL_ADD_SUB_EN
    issue(0, 8'h10, 8'h01, 0, 1, 8'h0F, 1);
    drain();
    issue(1, 8'h01, 8'h02, 0, 1, 8'hFF, 0);
    drain();
`endif
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
- Shares one combinational 1-bit full-adder cell between two requesters.
- Each accepted operation is a WIDTH-bit add, executed bit-serially LSB-first, one bit per clock.
- Round-robin arbitration, valid/ready request ports, a single response port with a requester ID.
- Sits between client blocks and the low-area adder datapath. Trades latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_cin  in  1  carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result when valid&ready
- resp_id  out  1  requester that issued the result
- resp_sum  out  WIDTH  sum
- resp_cout  out  1  carry-out of MSB

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: all registers 0; last_grant=1, so requester 0 wins the first tie. resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, both readys 0.
- Grant logic (IDLE only):
  - grant0 = req0_valid & (~req1_valid | last_grant==1)
  - grant1 = req1_valid & ~grant0
  - reqN_ready = (state==IDLE) & grantN. This is combinational from valid; the granted requester's ready is the only ready high.
  - Both readys are 0 in SHIFT and DONE.
- Accept: on reqN_valid&reqN_ready:
  - latch a, b, cin into shift regs and the carry reg; id=N; last_grant=N; bit_cnt=0; go to SHIFT.
- SHIFT, each cycle:
  - FA inputs: a_sh[0], b_sh[0], carry.
  - sum bit shifts into the MSB of sum_sh (sum_sh shifts right); carry <= FA cout.
  - a_sh and b_sh shift right; bit_cnt increments.
  - When bit_cnt==WIDTH-1, go to DONE.
- DONE:
  - resp_valid=1; resp_sum=sum_sh, resp_cout=carry and resp_id are held stable until resp_ready.
  - On resp_valid&resp_ready, go to IDLE.
  - New requests can be accepted in that IDLE cycle at the earliest.
- Latency: accept at edge T, resp_valid high after edge T+WIDTH.
- Minimum spacing between accepts: WIDTH+2 cycles with resp_ready tied high.
- Arithmetic: modulo 2^WIDTH; cout is the true carry-out. cin=1 with all-ones operands gives sum all-ones, cout=1.
- Backpressure: resp_ready low in DONE stalls indefinitely; no requests are accepted meanwhile.
- Requester valid dropping before grant is legal; no state change.
- Reset mid-operation: asynchronous return to IDLE, in-flight result discarded, outputs at reset values immediately.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN
- Defined:
  - adds ports req0_sub and req1_sub (in, 1), latched on accept.
  - When sub=1: B is inverted at load and carry-in is forced to 1 (reqN_cin ignored); the result is A-B.
  - resp_cout=1 means no borrow.
- Undefined: the ports are absent and the block is add-only.

Decomposition:
- Package serial_add_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - ID_W=1
  - counter width function clog2(WIDTH)
- One natural sub-module: fa_bit, the 1-bit combinational full adder (a, b, cin -> sum, cout), instantiated once in the datapath.
- Arbiter and FSM stay in the top module.

Test Plan:
- req0 a=0x3C b=0x0F cin=0, resp_ready=1 -> resp_sum=0x4B, cout=0, id=0; resp_valid first high exactly 8 cycles after the accept edge.
- req1 a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1, id=1. Then a=0xFF b=0xFF cin=1 -> sum=0xFF, cout=1.
- Both valid continuously with distinct operands -> accepts alternate 0,1,0,1 starting with 0; resp_id matches each; no request starved.
- resp_ready held low 5 cycles in DONE -> resp_sum/cout/id stable; req0_ready and req1_ready stay 0; accept occurs the cycle after the handshake.
- rst_n pulsed low at bit 3 of SHIFT -> resp_valid=0, outputs 0 asynchronously. Next op 0x12+0x34 -> 0x46 correct.
- SERIAL_ADD_SUB_EN: a=0x10 b=0x01 sub=1 -> sum=0x0F, cout=1; a=0x01 b=0x02 sub=1 -> sum=0xFF, cout=0.
